aes_round_ctrl: RTL and testbench

Sequencer between the AES-128 `Key_Schedule` block and the AES round datapath. On a start pulse it enables the key schedule and waits for its ready flag. It then walks `SelKey` through round keys 0..10, latches each key into a round-key register, and issues one handshaked round command per key to the datapath. It reports completion or a key-schedule timeout to the top-level controller.

---
 rtl/aes_ctrl_pkg.sv | 30 +++
 rtl/ks_watchdog.sv | 32 +++
 rtl/aes_round_ctrl.sv | 144 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
// Imported by aes_round_ctrl and its key-schedule watchdog.
package aes_ctrl_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;

  localparam logic [1:0] RT_INIT  = 2'd0;
  localparam logic [1:0] RT_MID   = 2'd1;
  localparam logic [1:0] RT_FINAL = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KS_WAIT,
    ST_SEL,
    ST_LOAD,
    ST_GO,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERR
  } state_e;

  // Round 0 is the bare AddRoundKey; the last round skips MixColumns.
  function automatic logic [1:0] round_type(input logic [3:0] round, input logic [3:0] nr);
    if (round == 4'd0) return RT_INIT;
    if (round == nr)   return RT_FINAL;
    return RT_MID;
  endfunction

endpackage

// File: rtl/ks_watchdog.sv
// Cycle counter bounding how long the sequencer waits for the key schedule.
// expired is high in the KS_TIMEOUT-th cycle after the last clear.
module ks_watchdog #(
  parameter int KS_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (KS_TIMEOUT > 1) ? $clog2(KS_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(KS_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer between the AES-128 key schedule and the round datapath: waits for the
// schedule, then fetches, latches and issues one handshaked round per round key.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR         = AES_NR,
  parameter int KEY_W      = AES_KEY_W,
  parameter int KEY_LAT    = 1,
  parameter int KS_TIMEOUT = 64
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic             KsEn,
  input  logic             KsRy,
  output logic [3:0]       SelKey,
  input  logic [KEY_W-1:0] KsKey,
  output logic [KEY_W-1:0] RoundKey,
  output logic             RoundGo,
  output logic [1:0]       RoundType,
  input  logic             RoundAck,
  output logic [3:0]       Round
);

  localparam logic [3:0] NR_L      = 4'(NR);
  localparam logic [1:0] LAT_LAST  = 2'(KEY_LAT - 1);

  state_e           state_q;
  logic [3:0]       round_q;
  logic [3:0]       sel_key_q;
  logic [1:0]       lat_q;
  logic [KEY_W-1:0] round_key_q;
  logic [1:0]       round_type_q;
  logic             busy_q, done_q, err_q, ks_en_q, go_q;

  logic wd_clr, wd_en, wd_expired;

  assign wd_clr = ((state_q == ST_IDLE) || (state_q == ST_ERR)) && Start;
  assign wd_en  = (state_q == ST_KS_WAIT);

  ks_watchdog #(.KS_TIMEOUT(KS_TIMEOUT)) u_ks_watchdog (
    .clk     (Clk),
    .rst     (Rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // NOTE: state is updated with non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      round_q      <= '0;
      sel_key_q    <= '0;
      lat_q        <= '0;
      // NOTE: the round-key register is reset because it is a visible output that must read 0 after reset.
      round_key_q  <= '0;
      round_type_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ks_en_q      <= 1'b0;
      go_q         <= 1'b0;
    end else begin
      go_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (Start) begin
            state_q   <= ST_KS_WAIT;
            round_q   <= '0;
            sel_key_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            ks_en_q   <= 1'b1;
          end
        end
        ST_KS_WAIT: begin
          if (KsRy) begin
            state_q   <= ST_SEL;
            sel_key_q <= round_q;
            lat_q     <= '0;
          end else if (wd_expired) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            ks_en_q <= 1'b0;
          end
        end
        ST_SEL: begin
          // Give the key schedule KEY_LAT cycles to settle on the new select.
          if (lat_q == LAT_LAST) state_q <= ST_LOAD;
          else                   lat_q   <= lat_q + 2'd1;
        end
        ST_LOAD: begin
          round_key_q  <= KsKey;
          round_type_q <= round_type(round_q, NR_L);
          go_q         <= 1'b1;
          state_q      <= ST_GO;
        end
        ST_GO: begin
          state_q <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (RoundAck) begin
            if (round_q >= NR_L) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              ks_en_q <= 1'b0;
            end else begin
              round_q   <= round_q + 4'd1;
              sel_key_q <= round_q + 4'd1;
              lat_q     <= '0;
              state_q   <= ST_SEL;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ks_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Error     = err_q;
  assign KsEn      = ks_en_q;
  assign SelKey    = sel_key_q;
  assign RoundKey  = round_key_q;
  assign RoundGo   = go_q;
  assign RoundType = round_type_q;
  assign Round     = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: one KEY_LAT=1 instance and one KEY_LAT=3 instance
// sharing a clock, with a behavioural key schedule whose output lags SelKey by KEY_LAT.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, ks_ry = 1'b0, round_ack = 1'b0, use_b = 1'b0;
  int   tests = 0, fails = 0;

  logic         a_busy, a_done, a_err, a_ksen, a_go, b_busy, b_done, b_err, b_ksen, b_go;
  logic [3:0]   a_sel, a_round, b_sel, b_round;
  logic [1:0]   a_rt, b_rt;
  logic [127:0] a_rkey, b_rkey, a_kskey, b_kskey;
  logic [3:0]   pa, pb1, pb2, pb3;

  function automatic logic [127:0] key_of(input logic [3:0] i);
    return {8{i, 12'hC3A}};
  endfunction

  always @(posedge clk) begin
    pa  <= a_sel;
    pb1 <= b_sel;
    pb2 <= pb1;
    pb3 <= pb2;
  end
  assign a_kskey = key_of(pa);
  assign b_kskey = key_of(pb3);

  logic a_start, a_ry, a_ack, b_start, b_ry, b_ack;
  assign a_start = start & ~use_b;
  assign a_ry    = ks_ry & ~use_b;
  assign a_ack   = round_ack & ~use_b;
  assign b_start = start & use_b;
  assign b_ry    = ks_ry & use_b;
  assign b_ack   = round_ack & use_b;

  aes_round_ctrl #(.NR(10), .KEY_W(128), .KEY_LAT(1), .KS_TIMEOUT(64)) dut_a (
    .Clk(clk), .Rst(rst), .Start(a_start), .Busy(a_busy), .Done(a_done), .Error(a_err),
    .KsEn(a_ksen), .KsRy(a_ry), .SelKey(a_sel), .KsKey(a_kskey), .RoundKey(a_rkey),
    .RoundGo(a_go), .RoundType(a_rt), .RoundAck(a_ack), .Round(a_round)
  );

  aes_round_ctrl #(.NR(10), .KEY_W(128), .KEY_LAT(3), .KS_TIMEOUT(64)) dut_b (
    .Clk(clk), .Rst(rst), .Start(b_start), .Busy(b_busy), .Done(b_done), .Error(b_err),
    .KsEn(b_ksen), .KsRy(b_ry), .SelKey(b_sel), .KsKey(b_kskey), .RoundKey(b_rkey),
    .RoundGo(b_go), .RoundType(b_rt), .RoundAck(b_ack), .Round(b_round)
  );

  logic         o_busy, o_done, o_err, o_ksen, o_go;
  logic [3:0]   o_sel, o_round;
  logic [1:0]   o_rt;
  logic [127:0] o_rkey;
  assign o_busy  = use_b ? b_busy  : a_busy;
  assign o_done  = use_b ? b_done  : a_done;
  assign o_err   = use_b ? b_err   : a_err;
  assign o_ksen  = use_b ? b_ksen  : a_ksen;
  assign o_go    = use_b ? b_go    : a_go;
  assign o_sel   = use_b ? b_sel   : a_sel;
  assign o_round = use_b ? b_round : a_round;
  assign o_rt    = use_b ? b_rt    : a_rt;
  assign o_rkey  = use_b ? b_rkey  : a_rkey;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {o_busy, o_done, o_err, o_ksen, o_go, o_rt, o_round, o_sel}, '0);
    check({tag, "_rkey"}, o_rkey, '0);
  endtask

  // Start pulse, then KsRy is raised in the ry_dly-th KS_WAIT cycle.
  task automatic start_run(input int ry_dly, input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_busy"}, o_busy, 1'b1);
    check({tag, "_ksen"}, o_ksen, 1'b1);
    check({tag, "_err"},  o_err,  1'b0);
    repeat (ry_dly - 1) @(negedge clk);
    ks_ry = 1'b1;
  endtask

  // Drives the round handshake; cyc counts cycles after the edge that sampled KsRy.
  task automatic run(input int ack_dly, input bit inject, input int rst_round,
                     input int exp_done, input string tag);
    int cyc = 0, next_r = 0, ack_at = -1, ack_off = -1, start_at = -1;
    int go_cnt = 0, done_cyc = -1, bad = 0;
    bit waiting = 1'b0;
    logic [127:0] hk;
    logic [1:0]   ht;
    logic [3:0]   hr;
    while (cyc < 400 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      ks_ry = 1'b0;
      start = (cyc == start_at);
      if (cyc == ack_off) round_ack = 1'b0;
      if (o_done) done_cyc = cyc;
      if (o_go) begin
        hk = key_of(4'(next_r));
        ht = (next_r == 0) ? 2'd0 : (next_r == 10) ? 2'd2 : 2'd1;
        hr = 4'(next_r);
        check($sformatf("%s_sel%0d", tag, next_r),   o_sel,   hr);
        check($sformatf("%s_round%0d", tag, next_r), o_round, hr);
        check($sformatf("%s_rt%0d", tag, next_r),    o_rt,    ht);
        check($sformatf("%s_rkey%0d", tag, next_r),  o_rkey,  hk);
        go_cnt++;
        waiting = 1'b1;
        ack_at  = cyc + 1 + ack_dly;
        ack_off = ack_at + 1;
        if (inject && next_r == 4) ack_off = ack_at + 2;
        if (inject && next_r == 5) start_at = cyc + 1;
        if (next_r == rst_round) begin
          rst = 1'b1; start = 1'b1;
          @(negedge clk);
          rst = 1'b0; start = 1'b0;
          check_all_zero({tag, "_after_rst"});
          return;
        end
        next_r++;
      end else if (waiting) begin
        if (o_rkey !== hk || o_rt !== ht || o_round !== hr || o_go !== 1'b0) bad++;
      end
      if (cyc == ack_at) begin
        round_ack = 1'b1;
        waiting   = 1'b0;
      end
    end
    check({tag, "_go_count"}, go_cnt, 11);
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_stable"}, bad, 0);
    check({tag, "_done_state"}, {o_busy, o_ksen, o_round}, {1'b1, 1'b0, 4'd10});
    @(negedge clk);
    check({tag, "_idle_after"}, {o_done, o_busy, o_go}, 3'b000);
  endtask

  initial begin
    int n, dones;
    repeat (3) @(negedge clk);
    check_all_zero("reset_a");
    use_b = 1'b1;
    check_all_zero("reset_b");
    use_b = 1'b0;
    rst = 1'b0;

    start_run(20, "nom");
    run(0, 1'b0, -1, 45, "nom");

    start_run(5, "slow");
    run(7, 1'b0, -1, 122, "slow");

    start_run(5, "ign");
    run(0, 1'b1, -1, 45, "ign");

    // Key schedule never reports ready: error after exactly KS_TIMEOUT cycles in KS_WAIT.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    check("to_ksen_on", o_ksen, 1'b1);
    while (n < 200 && o_err !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n - 1, 64);
    check("to_outputs", {o_err, o_ksen, o_busy}, 3'b100);
    repeat (3) @(negedge clk);
    check("to_sticky", o_err, 1'b1);
    start_run(20, "rec");
    run(0, 1'b0, -1, 45, "rec");

    start_run(4, "rst");
    run(0, 1'b0, 3, 0, "rst");
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_done || o_busy) dones++;
    end
    check("rst_stays_idle", dones, 0);
    start_run(4, "post");
    run(0, 1'b0, -1, 45, "post");

    use_b = 1'b1;
    start_run(3, "lat3");
    run(0, 1'b0, -1, 67, "lat3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
